// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter with lock in front of the
// single-port unified memory. Requester 0 is the core, requester 1 a loader/DMA.
// Ports: clk, reset (sync, active low); per requester i: req/we/lock/addr/wdata
// in, gnt (comb), rvalid/rdata out; memory side: writeEnable, address,
// dataToMemory out, dataFromMemory in (valid one cycle after address).
// Option: ARB_FIXED_PRIO_EN gives OPEN-state ties to requester 0 always.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataToMemory,
  input  logic [DATA_W-1:0] dataFromMemory
);

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  // read pipeline: issue stage (pend/own) and return stage (rvalid/rdata)
  logic              pend_q, pend_d;
  logic              own_q, own_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic              acc0, acc1, acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      OPEN: begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
          gnt0 = 1'b1;
`else
          // the requester that did not win last time goes now
          gnt0 = last_q;
          gnt1 = !last_q;
`endif
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      LOCK0: gnt0 = req0;
      LOCK1: gnt1 = req1;
      default: ;
    endcase
  end

  assign acc0 = req0 && gnt0;
  assign acc1 = req1 && gnt1;
  assign acc  = acc0 || acc1;

  assign sel_we    = acc1 ? we1    : we0;
  assign sel_addr  = acc1 ? addr1  : addr0;
  assign sel_wdata = acc1 ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (acc0) begin
      last_d  = 1'b0;
      state_d = lock0 ? LOCK0 : OPEN;
    end else if (acc1) begin
      last_d  = 1'b1;
      state_d = lock1 ? LOCK1 : OPEN;
    end else if (state_q == LOCK0 && !req0) begin
      // owner dropped its request: release
      state_d = OPEN;
    end else if (state_q == LOCK1 && !req1) begin
      state_d = OPEN;
    end
  end

  always_comb begin
    we_d   = acc && sel_we;
    addr_d = acc ? sel_addr : addr_q;
    wd_d   = (acc && sel_we) ? sel_wdata : wd_q;
    pend_d = acc && !sel_we;
    own_d  = acc1;
    rv0_d  = pend_q && !own_q;
    rv1_d  = pend_q && own_q;
    rd0_d  = rv0_d ? dataFromMemory : rd0_q;
    rd1_d  = rv1_d ? dataFromMemory : rd1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= OPEN;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      pend_q  <= 1'b0;
      own_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      pend_q  <= pend_d;
      own_q   <= own_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign writeEnable  = we_q;
  assign address      = addr_q;
  assign dataToMemory = wd_q;
  assign rvalid0      = rv0_q;
  assign rvalid1      = rv1_q;
  assign rdata0       = rd0_q;
  assign rdata1       = rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a memory model
// and a read-return scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        writeEnable;
  logic [15:0] address, dataToMemory, dataFromMemory;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .writeEnable(writeEnable), .address(address),
    .dataToMemory(dataToMemory), .dataFromMemory(dataFromMemory)
  );

  logic [15:0] mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (writeEnable) mem[address] <= dataToMemory;
  end
  assign dataFromMemory = mem[address];

  typedef struct {
    logic        owner;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic g0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic l,
                      input logic [15:0] a, input logic [15:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l,
                      input logic [15:0] a, input logic [15:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  // read accepted at the coming edge; data returns one edge later
  task automatic expect_rd(input logic o, input logic [15:0] d);
    sb.push_back('{owner: o, data: d, due: cyc + 2});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("rvalid0", {31'd0, rvalid0}, {31'd0, !mon_e.owner});
        chk("rvalid1", {31'd0, rvalid1}, {31'd0, mon_e.owner});
        chk("rdata", {16'd0, mon_e.owner ? rdata1 : rdata0},
            {16'd0, mon_e.data});
      end else begin
        chk("no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    set0(0, 0, 0, 16'h0, 16'h0);
    set1(0, 0, 0, 16'h0, 16'h0);
    tick();
    preload(16'h0010, 16'h1234);
    preload(16'h0001, 16'h1111);
    preload(16'h0002, 16'h2222);
    preload(16'h0020, 16'h5A5A);
    preload(16'h0030, 16'h3030);
    tick();
    mon_en = 1'b1;
    chk("rst_we", {31'd0, writeEnable}, 32'd0);
    chk("rst_addr", {16'd0, address}, 32'd0);
    chk("rst_dtm", {16'd0, dataToMemory}, 32'd0);
    chk("rst_rdata0", {16'd0, rdata0}, 32'd0);
    chk("rst_rdata1", {16'd0, rdata1}, 32'd0);
    chk("rst_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    reset = 1'b1;
    tick();

    // single read by requester 0
    set0(1, 0, 0, 16'h0010, 16'h0);
    #1;
    chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rd_gnt1", {31'd0, gnt1}, 32'd0);
    expect_rd(1'b0, 16'h1234);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    chk("rd_addr", {16'd0, address}, 32'h0010);
    chk("rd_we", {31'd0, writeEnable}, 32'd0);
    tick();
    chk("rd_we2", {31'd0, writeEnable}, 32'd0);
    tick();
    chk("rd_hold", {16'd0, rdata0}, 32'h1234);

    // requester 1 read so the next tie goes to requester 0
    set1(1, 0, 0, 16'h0020, 16'h0);
    #1;
    chk("r1_gnt1", {31'd0, gnt1}, 32'd1);
    expect_rd(1'b1, 16'h5A5A);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // both requesting for four cycles
    set0(1, 0, 0, 16'h0001, 16'h0);
    set1(1, 0, 0, 16'h0002, 16'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      g0 = 1'b1;
`else
      g0 = (k % 2 == 0);
`endif
      chk("tie_gnt0", {31'd0, gnt0}, {31'd0, g0});
      chk("tie_gnt1", {31'd0, gnt1}, {31'd0, !g0});
      expect_rd(!g0, g0 ? 16'h1111 : 16'h2222);
      tick();
    end
    set0(0, 0, 0, 16'h0, 16'h0);
    set1(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // requester 1 write then requester 0 reads it back
    set1(1, 1, 0, 16'h0100, 16'hBEEF);
    #1;
    chk("wr_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);
    chk("wr_we", {31'd0, writeEnable}, 32'd1);
    chk("wr_addr", {16'd0, address}, 32'h0100);
    chk("wr_dtm", {16'd0, dataToMemory}, 32'hBEEF);
    set0(1, 0, 0, 16'h0100, 16'h0);
    #1;
    chk("wb_gnt0", {31'd0, gnt0}, 32'd1);
    expect_rd(1'b0, 16'hBEEF);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    chk("wr_we_pulse", {31'd0, writeEnable}, 32'd0);
    tick();
    tick();

    // write then three idle cycles
    set1(1, 1, 0, 16'h0040, 16'hCAFE);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);
    chk("idle_we1", {31'd0, writeEnable}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_we", {31'd0, writeEnable}, 32'd0);
      chk("idle_addr", {16'd0, address}, 32'h0040);
      chk("idle_dtm", {16'd0, dataToMemory}, 32'hCAFE);
      chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    end

    // locked read then unlocking write by requester 0
    set0(1, 0, 1, 16'h0010, 16'h0);
    set1(1, 0, 0, 16'h0030, 16'h0);
    #1;
    chk("lk_gnt0", {31'd0, gnt0}, 32'd1);
    chk("lk_gnt1", {31'd0, gnt1}, 32'd0);
    expect_rd(1'b0, 16'h1234);
    tick();
    set0(1, 1, 0, 16'h0050, 16'h0777);
    #1;
    chk("lk2_gnt0", {31'd0, gnt0}, 32'd1);
    chk("lk2_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    #1;
    chk("ul_gnt1", {31'd0, gnt1}, 32'd1);
    expect_rd(1'b1, 16'h3030);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // lock released by the owner dropping its request
    set1(1, 0, 1, 16'h0020, 16'h0);
    #1;
    chk("rl_gnt1", {31'd0, gnt1}, 32'd1);
    expect_rd(1'b1, 16'h5A5A);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);
    set0(1, 0, 0, 16'h0001, 16'h0);
    #1;
    chk("rl_blk_gnt0", {31'd0, gnt0}, 32'd0);
    tick();
    chk("rl_open_gnt0", {31'd0, gnt0}, 32'd1);
    expect_rd(1'b0, 16'h1111);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // reset right after a read acceptance discards the return
    set0(1, 0, 0, 16'h0010, 16'h0);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    reset = 1'b0;
    tick();
    chk("rst2_we", {31'd0, writeEnable}, 32'd0);
    chk("rst2_addr", {16'd0, address}, 32'd0);
    chk("rst2_dtm", {16'd0, dataToMemory}, 32'd0);
    chk("rst2_rdata0", {16'd0, rdata0}, 32'd0);
    chk("rst2_rdata1", {16'd0, rdata1}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    set0(1, 0, 0, 16'h0002, 16'h0);
    set1(1, 0, 0, 16'h0001, 16'h0);
    #1;
    chk("rst2_tie0", {31'd0, gnt0}, 32'd1);
    chk("rst2_tie1", {31'd0, gnt1}, 32'd0);
    expect_rd(1'b0, 16'h2222);
    tick();
    set0(0, 0, 0, 16'h0, 16'h0);
    #1;
    chk("rst2_next1", {31'd0, gnt1}, 32'd1);
    expect_rd(1'b1, 16'h1111);
    tick();
    set1(0, 0, 0, 16'h0, 16'h0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    tick();
    chk("sb_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
